lsu_bus_if: RTL and testbench
=============================

Name: lsu_bus_if

Overview:
Memory-stage load/store unit sitting directly downstream of the pipeline controller's M-stage control outputs (MemWriteM, loadM) and the datapath's M-stage address/data. It converts each M-stage memory instruction into one request/acknowledge data-bus transaction, generates byte strobes and aligned write data, and sign/zero-extends load data. It stalls the pipeline while a transaction is outstanding and flags misaligned accesses and bus errors.

Parameters:
TIMEOUT, 255, maximum REQ cycles without mem_ack before the transaction is aborted as a bus error (1..255).

Ports:
clk  in  1  pipeline clock, rising edge
reset  in  1  asynchronous, active-high
MemWriteM  in  1  M-stage store
loadM  in  1  M-stage load
funct3M  in  3  M-stage funct3: 000 lb/sb, 001 lh/sh, 010 lw/sw, 100 lbu, 101 lhu
ALUResultM  in  32  byte address
WriteDataM  in  32  store data (rs2)
ReadDataM  out  32  extended load result, valid in DONE cycle
StallMem  out  1  hold F/D/E/M stages
MisalignM  out  1  misaligned or illegal-size access, current cycle
BusErrM  out  1  bus error or timeout, valid in DONE cycle
mem_req  out  1  bus request
mem_we  out  1  1 = write
mem_addr  out  32  word address, [1:0]=00
mem_wdata  out  32  lane-aligned write data
mem_wstrb  out  4  byte enables (0000 on reads)
mem_ack  in  1  transaction complete
mem_rdata  in  32  read word, valid with mem_ack
mem_err  in  1  error, valid with mem_ack

Behaviour:
- Reset (async, any state): state=IDLE; all outputs 0; timeout counter 0. Reset during REQ drops mem_req immediately; transaction is abandoned.
- access = MemWriteM | loadM. Both high is illegal decoder output; store takes priority.
- Legality: byte always aligned; half needs addr[0]=0; word needs addr[1:0]=00. funct3M 011/110/111, and 100/101 with a store, count as illegal.
- IDLE: access & illegal -> MisalignM=1 combinationally, no stall, no bus cycle, stay IDLE. access & legal -> StallMem=1 combinationally; register we, word address, wdata, wstrb, funct3, addr[1:0]; go REQ.
- REQ: mem_req=1, StallMem=1; mem_we/addr/wdata/wstrb held from registers and stable until ack. Counter increments each cycle. mem_ack -> latch extended load data (loads only) and BusErrM=mem_err; go DONE. Counter reaches TIMEOUT without ack -> drop mem_req, BusErrM=1, ReadDataM=0, go DONE. mem_ack arriving the same cycle as the timeout wins.
- DONE: mem_req=0, StallMem=0, ReadDataM/BusErrM held for exactly this cycle; pipeline advances the M instruction at end of cycle; go IDLE unconditionally (the next M instruction is evaluated in IDLE the following cycle, so there is one bubble per access). ReadDataM/BusErrM return to 0 in IDLE.
- Minimum latency: zero-wait-state slave (ack in first REQ cycle) -> 3 cycles per access (IDLE detect, REQ, DONE).
- Store lanes: sb: wstrb=0001<<a[1:0], wdata={4{b}}; sh: wstrb=a[1]?1100:0011, wdata={2{h}}; sw: 1111, data unchanged.
- Load extract: lane = mem_rdata>>(8*a[1:0]); lb/lh sign-extend from bit 7/15; lbu/lhu zero-extend; lw passthrough.
- On bus error or timeout, ReadDataM=0 regardless of mem_rdata.

Decomposition:
- Shared package: funct3 size/sign encodings (F3_B, F3_H, F3_W, F3_BU, F3_HU), FSM state encoding (IDLE, REQ, DONE), strobe constants (STRB_NONE=0000, STRB_ALL=1111).
- One combinational sub-module lsu_align: legality check, strobe/wdata lane generation, load extract/extend. The FSM, registers and timeout counter stay in lsu_bus_if.

Test Plan:
- sw addr 0x104, data 0xDEADBEEF, ack on 2nd REQ cycle -> mem_addr 0x104, wstrb 1111, wdata 0xDEADBEEF, StallMem high 3 cycles, one req, 4 cycles total.
- sb addr 0x203, data 0x000000A5 -> wstrb 1000, wdata 0xA5A5A5A5, mem_addr 0x200.
- lb addr 0x101, rdata 0x00008000 -> ReadDataM 0xFFFFFF80 in DONE; lbu same -> 0x00000080; lh addr 0x102, rdata 0x80000000 -> 0xFFFF8000.
- lw addr 0x102 -> MisalignM=1 same cycle, mem_req never asserted, StallMem=0, ReadDataM=0.
- Load, ack withheld -> after TIMEOUT REQ cycles mem_req drops, BusErrM=1, ReadDataM=0 in DONE; ack with mem_err=1 -> same BusErrM response.
- Reset asserted mid-REQ (between clock edges) -> mem_req and StallMem low immediately; after release, a new lw completes normally.

Source files
------------

// File: rtl/lsu_bus_if_pkg.sv
// Shared encodings for the memory-stage load/store unit: funct3 access sizes,
// controller states and byte-strobe constants.
package lsu_bus_if_pkg;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   localparam logic [3:0] STRB_NONE = 4'b0000;
   localparam logic [3:0] STRB_ALL  = 4'b1111;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      DONE = 2'd2
   } lsu_state_e;

   localparam int unsigned CNT_W = 8;

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: access legality, store strobes and replicated
// write data, and extraction plus sign/zero extension of load data.
module lsu_align
   import lsu_bus_if_pkg::*;
(
   input  logic [2:0]  funct3_i,
   input  logic        is_store_i,
   input  logic [1:0]  addr_lo_i,
   input  logic [31:0] wdata_i,
   output logic        legal_o,
   output logic [3:0]  wstrb_o,
   output logic [31:0] wdata_o,
   input  logic [2:0]  ld_funct3_i,
   input  logic [1:0]  ld_addr_lo_i,
   input  logic [31:0] rdata_i,
   output logic [31:0] rdata_o
);

   logic [31:0] lane;

   always_comb begin
      // NOTE: every output gets a default before the case so no path can infer a latch.
      legal_o = 1'b0;
      wstrb_o = STRB_NONE;
      wdata_o = wdata_i;
      case (funct3_i)
         F3_B: begin
            legal_o = 1'b1;
            if (is_store_i) begin
               wstrb_o = 4'b0001 << addr_lo_i;
               wdata_o = {4{wdata_i[7:0]}};
            end
         end
         F3_H: begin
            legal_o = ~addr_lo_i[0];
            if (is_store_i) begin
               wstrb_o = addr_lo_i[1] ? 4'b1100 : 4'b0011;
               wdata_o = {2{wdata_i[15:0]}};
            end
         end
         F3_W: begin
            legal_o = (addr_lo_i == 2'b00);
            if (is_store_i) begin
               wstrb_o = STRB_ALL;
            end
         end
         // Unsigned variants exist only for loads.
         F3_BU:   legal_o = ~is_store_i;
         F3_HU:   legal_o = ~is_store_i & ~addr_lo_i[0];
         default: legal_o = 1'b0;
      endcase
   end

   always_comb begin
      lane    = rdata_i >> {ld_addr_lo_i, 3'b000};
      rdata_o = lane;
      case (ld_funct3_i)
         F3_B:    rdata_o = {{24{lane[7]}}, lane[7:0]};
         F3_H:    rdata_o = {{16{lane[15]}}, lane[15:0]};
         F3_BU:   rdata_o = {24'd0, lane[7:0]};
         F3_HU:   rdata_o = {16'd0, lane[15:0]};
         default: rdata_o = lane;
      endcase
   end

endmodule

// File: rtl/lsu_bus_if.sv
// Memory-stage load/store unit: turns each M-stage access into one req/ack bus
// transaction, stalls the pipeline while it is outstanding, reports errors.
module lsu_bus_if
   import lsu_bus_if_pkg::*;
#(
   parameter int unsigned TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        MemWriteM,
   input  logic        loadM,
   input  logic [2:0]  funct3M,
   input  logic [31:0] ALUResultM,
   input  logic [31:0] WriteDataM,
   output logic [31:0] ReadDataM,
   output logic        StallMem,
   output logic        MisalignM,
   output logic        BusErrM,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic [3:0]  mem_wstrb,
   input  logic        mem_ack,
   input  logic [31:0] mem_rdata,
   input  logic        mem_err
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

   lsu_state_e       state_q;
   logic [CNT_W-1:0] cnt_q;
   logic             we_q;
   logic [31:0]      addr_q;
   logic [31:0]      wdata_q;
   logic [3:0]       wstrb_q;
   logic [2:0]       funct3_q;
   logic [1:0]       addr_lo_q;
   logic             req_q;
   logic [31:0]      rdata_q;
   logic             buserr_q;

   logic             access;
   logic             legal;
   logic [3:0]       wstrb_d;
   logic [31:0]      wdata_d;
   logic [31:0]      rdata_ext;

   // A simultaneous store and load is a decoder fault; the store wins.
   assign access = MemWriteM | loadM;

   lsu_align u_align (
      .funct3_i     (funct3M),
      .is_store_i   (MemWriteM),
      .addr_lo_i    (ALUResultM[1:0]),
      .wdata_i      (WriteDataM),
      .legal_o      (legal),
      .wstrb_o      (wstrb_d),
      .wdata_o      (wdata_d),
      .ld_funct3_i  (funct3_q),
      .ld_addr_lo_i (addr_lo_q),
      .rdata_i      (mem_rdata),
      .rdata_o      (rdata_ext)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         // NOTE: the bus-side holding registers are reset too, so every output is 0 out of reset.
         state_q   <= IDLE;
         cnt_q     <= '0;
         we_q      <= 1'b0;
         addr_q    <= '0;
         wdata_q   <= '0;
         wstrb_q   <= STRB_NONE;
         funct3_q  <= '0;
         addr_lo_q <= '0;
         req_q     <= 1'b0;
         rdata_q   <= '0;
         buserr_q  <= 1'b0;
      end else begin
         // NOTE: state registers use non-blocking assignment so every branch sees pre-edge values.
         case (state_q)
            IDLE: begin
               if (access && legal) begin
                  we_q      <= MemWriteM;
                  addr_q    <= {ALUResultM[31:2], 2'b00};
                  wdata_q   <= wdata_d;
                  wstrb_q   <= wstrb_d;
                  funct3_q  <= funct3M;
                  addr_lo_q <= ALUResultM[1:0];
                  cnt_q     <= '0;
                  req_q     <= 1'b1;
                  state_q   <= REQ;
               end
            end
            REQ: begin
               // An ack landing on the final allowed cycle still completes normally.
               if (mem_ack) begin
                  req_q    <= 1'b0;
                  buserr_q <= mem_err;
                  rdata_q  <= (!we_q && !mem_err) ? rdata_ext : '0;
                  state_q  <= DONE;
               end else if (cnt_q == CNT_LAST) begin
                  req_q    <= 1'b0;
                  buserr_q <= 1'b1;
                  rdata_q  <= '0;
                  state_q  <= DONE;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            DONE: begin
               rdata_q  <= '0;
               buserr_q <= 1'b0;
               state_q  <= IDLE;
            end
            default: begin
               req_q   <= 1'b0;
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign mem_req   = req_q;
   assign mem_we    = we_q;
   assign mem_addr  = addr_q;
   assign mem_wdata = wdata_q;
   assign mem_wstrb = wstrb_q;
   assign ReadDataM = rdata_q;
   assign BusErrM   = buserr_q;

   // Gated by reset so a held M-stage access cannot raise a stall while in reset.
   assign StallMem  = !reset && ((state_q == IDLE && access && legal) || state_q == REQ);
   assign MisalignM = !reset && state_q == IDLE && access && !legal;

endmodule

// File: tb/tb_lsu_bus_if.sv
// Self-checking bench for lsu_bus_if: directed and random accesses against a
// bus slave driven from the bench and a size/lane reference model.
module tb_lsu_bus_if;

   localparam int TB_TIMEOUT = 12;

   logic        clk;
   logic        reset;
   logic        MemWriteM;
   logic        loadM;
   logic [2:0]  funct3M;
   logic [31:0] ALUResultM;
   logic [31:0] WriteDataM;
   logic [31:0] ReadDataM;
   logic        StallMem;
   logic        MisalignM;
   logic        BusErrM;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_wstrb;
   logic        mem_ack;
   logic [31:0] mem_rdata;
   logic        mem_err;

   int checks;
   int failures;

   lsu_bus_if #(.TIMEOUT(TB_TIMEOUT)) dut (
      .clk        (clk),
      .reset      (reset),
      .MemWriteM  (MemWriteM),
      .loadM      (loadM),
      .funct3M    (funct3M),
      .ALUResultM (ALUResultM),
      .WriteDataM (WriteDataM),
      .ReadDataM  (ReadDataM),
      .StallMem   (StallMem),
      .MisalignM  (MisalignM),
      .BusErrM    (BusErrM),
      .mem_req    (mem_req),
      .mem_we     (mem_we),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_wstrb  (mem_wstrb),
      .mem_ack    (mem_ack),
      .mem_rdata  (mem_rdata),
      .mem_err    (mem_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   function automatic int model_size(input logic [2:0] f3);
      if (f3 == 3'd0 || f3 == 3'd4) return 1;
      if (f3 == 3'd1 || f3 == 3'd5) return 2;
      return 4;
   endfunction

   function automatic logic model_legal(input logic st, input logic [2:0] f3, input logic [31:0] a);
      if (!(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})) return 1'b0;
      if (st && f3[2]) return 1'b0;
      return (a % model_size(f3)) == 0;
   endfunction

   function automatic logic [3:0] model_strb(input logic st, input logic [2:0] f3, input logic [31:0] a);
      int mask;
      if (!st) return 4'd0;
      mask = (1 << model_size(f3)) - 1;
      return 4'(mask << (a % 4));
   endfunction

   function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] d);
      logic [31:0] b, h;
      b = d & 32'hFF;
      h = d & 32'hFFFF;
      case (model_size(f3))
         1:       return b * 32'h01010101;
         2:       return h * 32'h00010001;
         default: return d;
      endcase
   endfunction

   function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] rd);
      logic [31:0] v;
      v = rd >> (8 * (a % 4));
      case (f3)
         3'd0: begin v = v & 32'hFF;   if (v >= 32'h80)   v = v | 32'hFFFFFF00; end
         3'd1: begin v = v & 32'hFFFF; if (v >= 32'h8000) v = v | 32'hFFFF0000; end
         3'd4: v = v & 32'hFF;
         3'd5: v = v & 32'hFFFF;
         default: ;
      endcase
      return v;
   endfunction

   task automatic idle_inputs();
      MemWriteM  = 1'b0;
      loadM      = 1'b0;
      funct3M    = 3'd0;
      ALUResultM = '0;
      WriteDataM = '0;
   endtask

   // One M-stage access from its IDLE cycle through DONE and the following IDLE.
   // ack_at: REQ cycle (1-based) in which the slave acks; outside 1..TB_TIMEOUT means never.
   task automatic do_access(input logic we, input logic ld, input logic [2:0] f3,
                            input logic [31:0] addr, input logic [31:0] wd, input logic [31:0] rd,
                            input int ack_at, input logic err, output int n_req, output int n_stall);
      logic        acc, legal, timed_out, e_err;
      logic [31:0] e_rd;
      bit          done;
      acc     = we | ld;
      legal   = model_legal(we, f3, addr);
      n_req   = 0;
      n_stall = 0;
      MemWriteM  = we;
      loadM      = ld;
      funct3M    = f3;
      ALUResultM = addr;
      WriteDataM = wd;
      mem_ack    = 1'b0;
      mem_err    = 1'b0;
      @(negedge clk);
      checks++; if (MisalignM !== (acc && !legal)) begin failures++; $display("FAIL misalign f3=%0d addr=%h got=%b want=%b", f3, addr, MisalignM, acc && !legal); end
      checks++; if (StallMem !== (acc && legal)) begin failures++; $display("FAIL idle_stall f3=%0d addr=%h got=%b want=%b", f3, addr, StallMem, acc && legal); end
      if (StallMem === 1'b1) n_stall++;
      if (!(acc && legal)) begin
         checks++; if (mem_req !== 1'b0 || ReadDataM !== 32'd0 || BusErrM !== 1'b0) begin failures++; $display("FAIL illegal_quiet req=%b rd=%h err=%b want 0", mem_req, ReadDataM, BusErrM); end
         @(posedge clk); #1;
         idle_inputs();
         @(negedge clk);
         checks++; if (mem_req !== 1'b0 || StallMem !== 1'b0) begin failures++; $display("FAIL illegal_no_bus req=%b stall=%b want 0", mem_req, StallMem); end
         @(posedge clk); #1;
         return;
      end
      done = 0;
      while (!done) begin
         @(posedge clk); #1;
         n_req++;
         mem_ack   = (n_req == ack_at);
         mem_err   = err;
         mem_rdata = rd;
         @(negedge clk);
         checks++; if (mem_req !== 1'b1 || StallMem !== 1'b1) begin failures++; $display("FAIL req_cycle%0d req=%b stall=%b want 1", n_req, mem_req, StallMem); end
         checks++; if (mem_we !== we || mem_addr !== {addr[31:2], 2'b00} || mem_wstrb !== model_strb(we, f3, addr)) begin
            failures++; $display("FAIL bus_ctl we=%b addr=%h strb=%b want we=%b addr=%h strb=%b", mem_we, mem_addr, mem_wstrb, we, {addr[31:2], 2'b00}, model_strb(we, f3, addr)); end
         if (we) begin
            checks++; if (mem_wdata !== model_wdata(f3, wd)) begin failures++; $display("FAIL wdata got=%h want=%h", mem_wdata, model_wdata(f3, wd)); end
         end
         if (StallMem === 1'b1) n_stall++;
         if (n_req == ack_at || n_req >= TB_TIMEOUT) done = 1;
      end
      @(posedge clk); #1;
      mem_ack   = 1'b0;
      mem_err   = 1'b0;
      mem_rdata = $urandom;
      timed_out = (ack_at < 1 || ack_at > TB_TIMEOUT);
      e_err     = timed_out ? 1'b1 : err;
      e_rd      = (timed_out || err || we) ? 32'd0 : model_load(f3, addr, rd);
      @(negedge clk);
      checks++; if (mem_req !== 1'b0 || StallMem !== 1'b0) begin failures++; $display("FAIL done_ctl req=%b stall=%b want 0", mem_req, StallMem); end
      checks++; if (ReadDataM !== e_rd || BusErrM !== e_err) begin failures++; $display("FAIL done_data f3=%0d addr=%h rd=%h err=%b want rd=%h err=%b", f3, addr, ReadDataM, BusErrM, e_rd, e_err); end
      @(posedge clk); #1;
      idle_inputs();
      @(negedge clk);
      checks++; if (ReadDataM !== 32'd0 || BusErrM !== 1'b0 || mem_req !== 1'b0) begin failures++; $display("FAIL after_done rd=%h err=%b req=%b want 0", ReadDataM, BusErrM, mem_req); end
      @(posedge clk); #1;
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      reset = 1'b1;
      idle_inputs();
      mem_ack = 1'b0; mem_err = 1'b0; mem_rdata = '0;
      loadM = 1'b1; funct3M = 3'd2; ALUResultM = 32'h100;
      repeat (2) @(negedge clk);
      checks++; if ({mem_req, mem_we, StallMem, MisalignM, BusErrM} !== 5'd0 || ReadDataM !== 0 || mem_addr !== 0 || mem_wdata !== 0 || mem_wstrb !== 0) begin
         failures++; $display("FAIL reset_outputs req=%b stall=%b mis=%b err=%b rd=%h addr=%h want all 0", mem_req, StallMem, MisalignM, BusErrM, ReadDataM, mem_addr); end
      idle_inputs();
      reset = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_store_word();
      int nr, ns;
      do_access(1'b1, 1'b0, 3'd2, 32'h104, 32'hDEADBEEF, 32'h0, 2, 1'b0, nr, ns);
      checks++; if (nr !== 2 || ns !== 3) begin failures++; $display("FAIL sw_latency req_cycles=%0d stall_cycles=%0d want 2/3", nr, ns); end
   endtask

   task automatic test_store_sub();
      int nr, ns;
      do_access(1'b1, 1'b0, 3'd0, 32'h203, 32'h000000A5, 32'h0, 1, 1'b0, nr, ns);
      checks++; if (nr !== 1 || ns !== 2) begin failures++; $display("FAIL sb_latency req_cycles=%0d stall_cycles=%0d want 1/2", nr, ns); end
      do_access(1'b1, 1'b0, 3'd1, 32'h302, 32'h1234BEEF, 32'h0, 3, 1'b0, nr, ns);
      do_access(1'b1, 1'b1, 3'd0, 32'h401, 32'h0000005A, 32'hFFFFFFFF, 1, 1'b0, nr, ns);
   endtask

   task automatic test_loads();
      int nr, ns;
      do_access(1'b0, 1'b1, 3'd0, 32'h101, 32'h0, 32'h00008000, 1, 1'b0, nr, ns);
      do_access(1'b0, 1'b1, 3'd4, 32'h101, 32'h0, 32'h00008000, 1, 1'b0, nr, ns);
      do_access(1'b0, 1'b1, 3'd1, 32'h102, 32'h0, 32'h80000000, 2, 1'b0, nr, ns);
      do_access(1'b0, 1'b1, 3'd5, 32'h102, 32'h0, 32'h80000000, 1, 1'b0, nr, ns);
      do_access(1'b0, 1'b1, 3'd2, 32'h100, 32'h0, 32'hCAFEF00D, 1, 1'b0, nr, ns);
      checks++; if (nr !== 1 || ns !== 2) begin failures++; $display("FAIL lw_min_latency req_cycles=%0d stall_cycles=%0d want 1/2", nr, ns); end
   endtask

   task automatic test_misalign();
      int nr, ns;
      do_access(1'b0, 1'b1, 3'd2, 32'h102, 32'h0, 32'h0, 1, 1'b0, nr, ns);
      do_access(1'b0, 1'b1, 3'd1, 32'h103, 32'h0, 32'h0, 1, 1'b0, nr, ns);
      do_access(1'b1, 1'b0, 3'd2, 32'h101, 32'h5, 32'h0, 1, 1'b0, nr, ns);
      do_access(1'b0, 1'b1, 3'd3, 32'h100, 32'h0, 32'h0, 1, 1'b0, nr, ns);
      do_access(1'b1, 1'b0, 3'd4, 32'h100, 32'h7, 32'h0, 1, 1'b0, nr, ns);
      checks++; if (nr !== 0 || ns !== 0) begin failures++; $display("FAIL illegal_counts req_cycles=%0d stall_cycles=%0d want 0/0", nr, ns); end
   endtask

   task automatic test_timeout();
      int nr, ns;
      do_access(1'b0, 1'b1, 3'd2, 32'h500, 32'h0, 32'h12345678, 0, 1'b0, nr, ns);
      checks++; if (nr !== TB_TIMEOUT) begin failures++; $display("FAIL timeout_len req_cycles=%0d want %0d", nr, TB_TIMEOUT); end
      do_access(1'b0, 1'b1, 3'd2, 32'h504, 32'h0, 32'h87654321, TB_TIMEOUT, 1'b0, nr, ns);
      do_access(1'b0, 1'b1, 3'd0, 32'h507, 32'h0, 32'h80FFFFFF, 3, 1'b1, nr, ns);
      do_access(1'b1, 1'b0, 3'd2, 32'h508, 32'h11, 32'h0, 2, 1'b1, nr, ns);
   endtask

   task automatic test_reset_mid_req();
      int nr, ns;
      loadM = 1'b1; funct3M = 3'd2; ALUResultM = 32'h600; mem_ack = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #2;
      reset = 1'b1;
      #1;
      checks++; if (mem_req !== 1'b0 || StallMem !== 1'b0 || MisalignM !== 1'b0) begin failures++; $display("FAIL reset_mid_req req=%b stall=%b mis=%b want 0", mem_req, StallMem, MisalignM); end
      @(negedge clk);
      idle_inputs();
      reset = 1'b0;
      @(posedge clk); #1;
      do_access(1'b0, 1'b1, 3'd2, 32'h604, 32'h0, 32'hA5A55A5A, 2, 1'b0, nr, ns);
   endtask

   task automatic test_random();
      logic [2:0] f3_tab [8] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd3, 3'd6, 3'd7};
      int nr, ns;
      for (int i = 0; i < 40; i++) begin
         logic we, ld, err;
         logic [2:0] f3;
         int ack_at;
         we     = 1'($urandom % 2);
         ld     = we ? ($urandom % 4 == 0) : 1'b1;
         f3     = ($urandom % 6 == 0) ? f3_tab[5 + $urandom % 3] : f3_tab[$urandom % 5];
         err    = ($urandom % 8 == 0);
         ack_at = ($urandom % 16 == 0) ? 0 : int'($urandom_range(1, 4));
         do_access(we, ld, f3, $urandom, $urandom, $urandom, ack_at, err, nr, ns);
      end
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      test_reset();
      test_store_word();
      test_store_sub();
      test_loads();
      test_misalign();
      test_timeout();
      test_reset_mid_req();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
